// File: rtl/gearbox_256_64_pkg.sv
// Shared PCS datapath constants and lane helpers for the 256-to-64 gearbox.
package gearbox_256_64_pkg;

  localparam int PCS_W256   = 256;
  localparam int PCS_W64    = 64;
  localparam int RATIO      = PCS_W256 / PCS_W64;
  localparam int LANE_IDX_W = $clog2(RATIO);
  localparam int GB_DEPTH   = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  function automatic logic is_last_beat(input lane_idx_t beat);
    return beat == lane_idx_t'(RATIO - 1);
  endfunction

  function automatic lane_idx_t next_beat(input lane_idx_t beat);
    return is_last_beat(beat) ? '0 : beat + 1'b1;
  endfunction

endpackage

// File: rtl/gb_pingpong_buf.sv
// Two-entry word buffer with wrapping read/write pointers; the occupancy count
// tells full from empty since the pointers alone cannot.
module gb_pingpong_buf
  import gearbox_256_64_pkg::*;
#(
  parameter int IN_W  = PCS_W256,
  parameter int DEPTH = GB_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             rel,
  input  logic [IN_W-1:0]  wdata,
  output logic [IN_W-1:0]  rdata,
  output logic [CNT_W-1:0] count_next,
  output logic             full,
  output logic             empty
);

  logic [IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count_next = count + CNT_W'(push) - CNT_W'(rel);
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign rdata      = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rel) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

endmodule

// File: rtl/gearbox_256_64.sv
// Serialises 256-bit words into four 64-bit beats, lane 0 first, with a
// ping-pong buffer so the next word can land while the current one drains.
module gearbox_256_64
  import gearbox_256_64_pkg::*;
#(
  parameter int IN_W   = PCS_W256,
  parameter int LANE_W = PCS_W64,
  parameter int DEPTH  = GB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_enable,
  output logic                  out_idle,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_datavalid,
  output logic [LANE_W-1:0]     out_data,
  output logic                  out_datavalid,
  output logic [LANE_IDX_W-1:0] out_lane_idx,
  input  logic                  in_idle
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             rel;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count_next;
  logic [IN_W-1:0]  rd_word;
  logic [LANE_W-1:0] lane_word;
  logic [LANE_W-1:0] data_hold;
  lane_idx_t        beat;
  logic             out_idle_q;

  gb_pingpong_buf #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .rel        (rel),
    .wdata      (in_data),
    .rdata      (rd_word),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // in_datavalid without out_idle is a protocol error and is dropped here.
  assign push = in_enable & in_datavalid & out_idle & ~full;
  assign pop  = in_enable & in_idle & ~empty;
  assign rel  = pop & is_last_beat(beat);

  assign out_idle      = out_idle_q & in_enable;
  assign out_datavalid = pop;
  assign out_lane_idx  = beat;
  assign lane_word     = rd_word[int'(beat) * LANE_W +: LANE_W];
  // With nothing buffered the line keeps showing the last beat driven.
  assign out_data      = empty ? data_hold : lane_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      out_idle_q <= 1'b0;
      data_hold  <= '0;
    end else if (in_enable) begin
      if (pop) beat <= next_beat(beat);
      out_idle_q <= (count_next < CNT_W'(DEPTH));
      data_hold  <= out_data;
    end
  end

endmodule

// File: tb/tb_gearbox_256_64.sv
// Directed bench for gearbox_256_64 with a queue-based reference model checked every cycle.
module tb_gearbox_256_64;

  localparam int IN_W   = 256;
  localparam int LANE_W = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_enable = 1'b1;
  logic              in_datavalid = 1'b0;
  logic              in_idle = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              out_idle;
  logic              out_datavalid;
  logic [LANE_W-1:0] out_data;
  logic [1:0]        out_lane_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gearbox_256_64 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_enable     (in_enable),
    .out_idle      (out_idle),
    .in_data       (in_data),
    .in_datavalid  (in_datavalid),
    .out_data      (out_data),
    .out_datavalid (out_datavalid),
    .out_lane_idx  (out_lane_idx),
    .in_idle       (in_idle)
  );

  // Reference model: a queue of whole words plus the lane position in the head word.
  logic [IN_W-1:0]   mq[$];
  int                mpos = 0;
  logic              m_idle_q = 1'b0;
  logic [LANE_W-1:0] m_last = '0;

  function automatic logic m_idle();
    return m_idle_q & in_enable;
  endfunction

  function automatic logic m_valid();
    return in_enable & in_idle & (mq.size() != 0);
  endfunction

  function automatic logic [LANE_W-1:0] m_data();
    logic [IN_W-1:0] w;
    if (mq.size() == 0) return m_last;
    w = mq[0];
    return w[mpos*LANE_W +: LANE_W];
  endfunction

  initial begin
    logic pushed;
    logic popped;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        mpos     = 0;
        m_idle_q = 1'b0;
        m_last   = '0;
      end else if (in_enable) begin
        m_last = m_data();
        pushed = in_datavalid && m_idle();
        popped = m_valid();
        if (popped) begin
          mpos++;
          if (mpos == 4) begin
            mpos = 0;
            void'(mq.pop_front());
          end
        end
        if (pushed) mq.push_back(in_data);
        m_idle_q = (mq.size() < 2);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_out_idle", 64'(out_idle), 64'(m_idle()));
      chk("cmp_out_datavalid", 64'(out_datavalid), 64'(m_valid()));
      chk("cmp_out_lane_idx", 64'(out_lane_idx), 64'(mpos));
      chk("cmp_out_data", out_data, m_data());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [IN_W-1:0] mkword(input int base);
    logic [IN_W-1:0] w;
    for (int i = 0; i < 4; i++) w[i*LANE_W +: LANE_W] = 64'(base + i);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [IN_W-1:0] w);
    int n;
    n = 0;
    while (!out_idle && n < 10) begin
      step();
      n++;
    end
    chk("push_ready", 64'(out_idle), 64'd1);
    in_data      = w;
    in_datavalid = 1'b1;
    step();
    in_datavalid = 1'b0;
  endtask

  task automatic drain();
    in_idle = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    int idx;
    int words;
    int beats;
    int first;
    int gaps;

    // Reset state
    #2;
    chk("rst_out_idle", 64'(out_idle), 64'd0);
    chk("rst_valid", 64'(out_datavalid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_lane", 64'(out_lane_idx), 64'd0);
    step();
    reset_n = 1'b1;
    chk("post_rst_idle_low", 64'(out_idle), 64'd0);
    step();
    chk("post_rst_idle_high", 64'(out_idle), 64'd1);

    // Single word, lane i carries i
    in_idle = 1'b1;
    push_word(mkword(0));
    for (int i = 0; i < 4; i++) begin
      chk("w0_valid", 64'(out_datavalid), 64'd1);
      chk("w0_lane", 64'(out_lane_idx), 64'(i));
      chk("w0_data", out_data, 64'(i));
      step();
    end
    chk("w0_done", 64'(out_datavalid), 64'd0);
    chk("w0_hold", out_data, 64'd3);

    // Fill both entries, then drain
    in_idle = 1'b0;
    push_word(mkword(32'h10));
    push_word(mkword(32'h20));
    chk("full_idle_low", 64'(out_idle), 64'd0);
    step();
    chk("full_idle_low2", 64'(out_idle), 64'd0);
    chk("full_no_valid", 64'(out_datavalid), 64'd0);
    in_idle = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("pp_valid", 64'(out_datavalid), 64'd1);
      chk("pp_lane", 64'(out_lane_idx), 64'(k % 4));
      chk("pp_data", out_data, (k < 4) ? 64'(32'h10 + k) : 64'(32'h20 + k - 4));
      chk("pp_idle", 64'(out_idle), (k >= 4) ? 64'd1 : 64'd0);
      step();
    end
    chk("pp_done", 64'(out_datavalid), 64'd0);
    drain();

    // in_idle toggling mid-word
    in_idle = 1'b0;
    push_word(mkword(32'h30));
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_idle = (c % 2 == 0);
      #1;
      chk("tog_lane", 64'(out_lane_idx), 64'(idx));
      chk("tog_data", out_data, 64'(32'h30 + idx));
      chk("tog_valid", 64'(out_datavalid), 64'(in_idle));
      if (in_idle) idx++;
      step();
    end
    chk("tog_all_lanes", 64'(idx), 64'd4);
    drain();

    // in_enable low while at lane 2
    push_word(mkword(32'h40));
    step();
    step();
    in_enable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("en_valid", 64'(out_datavalid), 64'd0);
      chk("en_idle", 64'(out_idle), 64'd0);
      chk("en_lane", 64'(out_lane_idx), 64'd2);
      step();
    end
    in_enable = 1'b1;
    #1;
    chk("en_l2_valid", 64'(out_datavalid), 64'd1);
    chk("en_l2_data", out_data, 64'h42);
    step();
    chk("en_l3_lane", 64'(out_lane_idx), 64'd3);
    chk("en_l3_data", out_data, 64'h43);
    step();
    chk("en_done", 64'(out_datavalid), 64'd0);
    drain();

    // Continuous streaming of 100 words
    words = 0;
    beats = 0;
    first = -1;
    gaps  = 0;
    for (int cyc = 0; cyc < 1000 && beats < 400; cyc++) begin
      if (out_idle && words < 100) begin
        in_data      = mkword(32'h1000 + words * 4);
        in_datavalid = 1'b1;
        words++;
      end else begin
        in_datavalid = 1'b0;
      end
      if (out_datavalid) begin
        chk("stream_data", out_data, 64'(32'h1000 + beats));
        if (first < 0) first = cyc;
        beats++;
      end else if (first >= 0) begin
        gaps++;
      end
      step();
    end
    in_datavalid = 1'b0;
    chk("stream_beats", 64'(beats), 64'd400);
    chk("stream_words", 64'(words), 64'd100);
    chk("stream_gaps", 64'(gaps), 64'd0);
    drain();

    // Reset mid-word with a second word queued
    push_word(mkword(32'h60));
    push_word(mkword(32'h70));
    chk("mid_lane1", 64'(out_lane_idx), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_datavalid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_lane", 64'(out_lane_idx), 64'd0);
    chk("mid_rst_idle", 64'(out_idle), 64'd0);
    step();
    reset_n = 1'b1;
    chk("mid_post_idle_low", 64'(out_idle), 64'd0);
    step();
    push_word(mkword(32'h80));
    for (int i = 0; i < 4; i++) begin
      chk("mid_new_lane", 64'(out_lane_idx), 64'(i));
      chk("mid_new_data", out_data, 64'(32'h80 + i));
      step();
    end
    chk("mid_done", 64'(out_datavalid), 64'd0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gearbox_256_64.md
Name: gearbox_256_64

Overview:
- Downstream neighbour of the 192-to-256 gearbox in the 25G PCS datapath.
- Accepts 256-bit words over the same valid/idle handshake and serialises each word into four 64-bit beats, lane 0 first, for the 64-bit line-side stage.
- Holds a 2-entry ping-pong buffer, so a new 256-bit word can be accepted while the previous one is still draining.

Parameters:
- IN_W, 256, input word width.
- LANE_W, 64, output beat width. IN_W must be an exact multiple; RATIO = IN_W/LANE_W = 4.
- DEPTH, 2, buffer entries. Fixed at 2 (ping-pong).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_enable  input  1  global enable; low freezes all state.
- out_idle  output  1  to upstream: a word is accepted this cycle if in_datavalid=1.
- in_data  input  IN_W  word from upstream gearbox.
- in_datavalid  input  1  in_data valid; asserted only when out_idle=1.
- out_data  output  LANE_W  current beat.
- out_datavalid  output  1  beat transferred this cycle.
- out_lane_idx  output  2  index (0..3) of the beat on out_data.
- in_idle  input  1  from downstream: can accept a beat this cycle.

Behaviour:
- Reset (async assert, sync release) values:
  - out_idle=0 for the first cycle, then 1.
  - out_datavalid=0, out_data=0, out_lane_idx=0.
  - Buffer count=0, write pointer=0, read pointer=0, beat counter=0, buffer contents cleared.
- State:
  - buf[0..1] of IN_W bits, wr_ptr (1b), rd_ptr (1b), count (0..2), beat (2b).
- Push:
  - Occurs when in_enable & in_datavalid & out_idle.
  - Writes in_data into buf[wr_ptr] and toggles wr_ptr.
  - in_datavalid while out_idle=0 is a protocol error: data is ignored and state is unchanged.
- Pop beat:
  - out_datavalid = in_enable & in_idle & (count!=0). This is combinational from in_idle by design.
  - out_data = buf[rd_ptr][beat*LANE_W +: LANE_W], out_lane_idx = beat.
  - These are driven from registered state whenever count!=0. out_data holds its last value when count==0.
  - On out_datavalid the beat counter increments. When beat==3 it wraps to 0, rd_ptr toggles and the word is released.
- Count update:
  - count_next = count + push - release.
  - Push and release in the same cycle leave count unchanged.
- out_idle:
  - Registered: out_idle_q <= (count_next < 2).
  - Output out_idle = out_idle_q & in_enable.
  - Accept-to-first-beat latency is 1 cycle: the word pushed in cycle t drives lane 0 in cycle t+1 if in_idle=1.
- Boundaries:
  - Full (count==2): out_idle=0 from the next cycle. The cycle in which lane 3 of the head word pops, out_idle_q is set to 1 for the following cycle.
  - Empty: out_datavalid=0 regardless of in_idle. The beat counter stays at 0.
  - in_idle low mid-word: the current beat is held (same out_data, same out_lane_idx) until in_idle returns. No beat is skipped or repeated.
  - in_enable low: no push, no pop, out_datavalid=0, out_idle=0. All registers hold. Operation resumes exactly where it stopped.
  - Wrap: wr_ptr and rd_ptr are 1-bit and toggle naturally. count disambiguates full from empty.
  - Reset mid-word: partial word and buffered words are discarded, and the first beat after reset is lane 0 of the next accepted word.
- Throughput:
  - Sustained 1 word per 4 cycles with in_idle=1.
  - Upstream sees out_idle=1 at least once every 4 cycles.

Decomposition:
- Shared PCS package holds:
  - Constants PCS_W256=256, PCS_W64=64.
  - Localparam RATIO and the lane-index width.
- One natural sub-module: gb_pingpong_buf (2-entry IN_W buffer with pointers, count and full/empty flags).
- The gearbox_256_64 top keeps the beat counter, output mux and handshake logic.

Test Plan:
- Reset, then push W0 with word 0x…0003_0000…0002_0000…0001_0000…0000 (lane i = i), in_idle=1 -> beats with out_lane_idx 0,1,2,3 carrying 0x0,0x1,0x2,0x3 in cycles t+1..t+4.
- Push W0 and W1 back-to-back (out_idle=1 both cycles) with in_idle=0 -> out_idle falls to 0 the cycle after the second push and count=2. Releasing in_idle then yields 8 beats, W0 lanes then W1 lanes, and out_idle rises the cycle after W0 lane 3.
- Toggle in_idle 1,0,1,0 during a word -> each lane appears exactly once and lane order is preserved, with out_data stable through the stalled cycles.
- Drop in_enable for 5 cycles while at lane 2 -> no out_datavalid and out_idle=0 during the stall. After re-enable, lane 2 then lane 3 are emitted.
- Continuous push (every cycle out_idle is high) with in_idle=1 for 100 words of incrementing data -> 400 beats in order, no gaps after the first beat, and no overflow.
- Assert reset_n low at lane 1 with one word queued -> outputs go to reset values immediately. The next accepted word starts at lane 0, and the old data never appears.
